// File: rtl/tmr_pkg.sv
// Shared encodings and the prescaler tap table for the 8-bit timer channel.
package tmr_pkg;

  // Count source select (TCR.CKS)
  localparam logic [2:0] CKS_STOP  = 3'b000;
  localparam logic [2:0] CKS_P2    = 3'b001;
  localparam logic [2:0] CKS_P8    = 3'b010;
  localparam logic [2:0] CKS_P32   = 3'b011;
  localparam logic [2:0] CKS_P64   = 3'b100;
  localparam logic [2:0] CKS_P1024 = 3'b101;
  localparam logic [2:0] CKS_P8192 = 3'b110;
  localparam logic [2:0] CKS_EXT   = 3'b111;

  // External clock edge select (11 is an alias for rising)
  localparam logic [1:0] EDGE_RISE     = 2'b00;
  localparam logic [1:0] EDGE_FALL     = 2'b01;
  localparam logic [1:0] EDGE_BOTH     = 2'b10;
  localparam logic [1:0] EDGE_RISE_ALT = 2'b11;

  // Counter clear mode (11 is an alias for none)
  localparam logic [1:0] CCLR_NONE     = 2'b00;
  localparam logic [1:0] CCLR_A        = 2'b01;
  localparam logic [1:0] CCLR_B        = 2'b10;
  localparam logic [1:0] CCLR_NONE_ALT = 2'b11;

  // Flag bit positions in the flag vector / flag_clr / int_en
  localparam int FLG_CMFA = 0;
  localparam int FLG_CMFB = 1;
  localparam int FLG_OVF  = 2;

  // Internal prescaler taps: tick index i serves CKS = i+1
  localparam int NUM_TAPS = 6;

  // log2(N) for each internal tap: P/2, P/8, P/32, P/64, P/1024, P/8192
  function automatic int tap_log2(input int idx);
    case (idx)
      0:       return 1;
      1:       return 3;
      2:       return 5;
      3:       return 6;
      4:       return 10;
      default: return 13;
    endcase
  endfunction

endpackage

// File: rtl/tmr_count_ctrl_if.sv
// Register-side / interrupt-side bundle of the timer count controller.
interface tmr_count_ctrl_if #(
  parameter int BIT_WIDTH = 8
);
  logic [2:0]           tcr_cks;
  logic [1:0]           tcr_edge;
  logic [1:0]           tcr_cclr;
  logic [BIT_WIDTH-1:0] tcora;
  logic [BIT_WIDTH-1:0] tcorb;
  logic                 tcnt_wr_en;
  logic [BIT_WIDTH-1:0] tcnt_wr_data;
  logic [2:0]           flag_clr;
  logic [2:0]           int_en;
  logic [BIT_WIDTH-1:0] tcnt;
  logic                 count_en;
  logic                 cmfa;
  logic                 cmfb;
  logic                 ovf;
  logic                 irq;

  // Register block / CPU side
  modport master (
    output tcr_cks, tcr_edge, tcr_cclr, tcora, tcorb,
           tcnt_wr_en, tcnt_wr_data, flag_clr, int_en,
    input  tcnt, count_en, cmfa, cmfb, ovf, irq
  );

  // Timer count controller side
  modport slave (
    input  tcr_cks, tcr_edge, tcr_cclr, tcora, tcorb,
           tcnt_wr_en, tcnt_wr_data, flag_clr, int_en,
    output tcnt, count_en, cmfa, cmfb, ovf, irq
  );
endinterface

// File: rtl/tmr_prescaler.sv
// Free-running prescaler producing one-cycle P/N ticks for every internal tap.
module tmr_prescaler
  import tmr_pkg::*;
#(
  parameter int PSC_WIDTH = 13
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic [NUM_TAPS-1:0] tick
);

  logic [PSC_WIDTH-1:0] r_psc;

  // Prescaler counts every clock and wraps naturally at 2^PSC_WIDTH
  always_ff @(posedge clk) begin
    if (!rst_n) r_psc <= '0;
    else        r_psc <= r_psc + 1'b1;
  end

  // A P/N tick is the cycle in which the low log2(N) bits are all ones
  for (genvar gi = 0; gi < NUM_TAPS; gi++) begin : g_tap
    localparam int L = tap_log2(gi);
    assign tick[gi] = &r_psc[L-1:0];
  end

endmodule

// File: rtl/tmr_count_ctrl.sv
// Count-control sequencer for one 8-bit timer channel: source select,
// external edge detect, TCNT with compare match / clear / overflow and flags.
module tmr_count_ctrl
  import tmr_pkg::*;
#(
  parameter int BIT_WIDTH = 8,
  parameter int PSC_WIDTH = 13
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            tmci,
  tmr_count_ctrl_if.slave bus
);

  logic [NUM_TAPS-1:0]  w_tick;
  logic                 r_tmci_p0, r_tmci_p1, r_tmci_p2;
  logic                 w_ext_tick;
  logic                 w_count_en;
  logic                 w_match_a, w_match_b;
  logic                 w_clear;
  logic                 w_wrap;
  logic [2:0]           w_flag_set;
  logic [BIT_WIDTH-1:0] r_tcnt;
  logic [2:0]           r_flags;

  // Sticky flag update: a set in the same cycle as a clear wins
  function automatic logic [2:0] flag_next(input logic [2:0] cur,
                                           input logic [2:0] set,
                                           input logic [2:0] clr);
    return set | (cur & ~clr);
  endfunction

  tmr_prescaler #(.PSC_WIDTH(PSC_WIDTH)) u_psc (
    .clk   (clk),
    .rst_n (rst_n),
    .tick  (w_tick)
  );

  // tmci synchronizer (p0, p1) and edge-history flop (p2)
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_tmci_p0 <= 1'b0;
      r_tmci_p1 <= 1'b0;
      r_tmci_p2 <= 1'b0;
    end else begin
      // stage p0 -> p1 -> p2
      r_tmci_p0 <= tmci;
      r_tmci_p1 <= r_tmci_p0;
      r_tmci_p2 <= r_tmci_p1;
    end
  end

  // Select the external edge type and the active count source
  always_comb begin
    w_ext_tick = r_tmci_p1 & ~r_tmci_p2;
    case (bus.tcr_edge)
      EDGE_FALL:     w_ext_tick = ~r_tmci_p1 & r_tmci_p2;
      EDGE_BOTH:     w_ext_tick = r_tmci_p1 ^ r_tmci_p2;
      EDGE_RISE,
      EDGE_RISE_ALT: w_ext_tick = r_tmci_p1 & ~r_tmci_p2;
      default:       w_ext_tick = r_tmci_p1 & ~r_tmci_p2;
    endcase

    w_count_en = 1'b0;
    case (bus.tcr_cks)
      CKS_STOP:  w_count_en = 1'b0;
      CKS_P2:    w_count_en = w_tick[0];
      CKS_P8:    w_count_en = w_tick[1];
      CKS_P32:   w_count_en = w_tick[2];
      CKS_P64:   w_count_en = w_tick[3];
      CKS_P1024: w_count_en = w_tick[4];
      CKS_P8192: w_count_en = w_tick[5];
      CKS_EXT:   w_count_en = w_ext_tick;
      default:   w_count_en = 1'b0;
    endcase
  end

  // Match, clear and wrap events, all judged on the pre-update counter;
  // a CPU write in the same cycle suppresses every event
  always_comb begin
    w_match_a = w_count_en & (r_tcnt == bus.tcora);
    w_match_b = w_count_en & (r_tcnt == bus.tcorb);
    w_clear   = ((bus.tcr_cclr == CCLR_A) & w_match_a) |
                ((bus.tcr_cclr == CCLR_B) & w_match_b);
    w_wrap    = w_count_en & ~w_clear & (&r_tcnt);

    w_flag_set           = 3'b000;
    w_flag_set[FLG_CMFA] = ~bus.tcnt_wr_en & w_match_a;
    w_flag_set[FLG_CMFB] = ~bus.tcnt_wr_en & w_match_b;
    w_flag_set[FLG_OVF]  = ~bus.tcnt_wr_en & w_wrap;
  end

  // TCNT: CPU write, then clear-on-match, then increment, else hold
  always_ff @(posedge clk) begin
    if (!rst_n)              r_tcnt <= '0;
    else if (bus.tcnt_wr_en) r_tcnt <= bus.tcnt_wr_data;
    else if (w_clear)        r_tcnt <= '0;
    else if (w_count_en)     r_tcnt <= r_tcnt + 1'b1;
  end

  // Sticky compare-match and overflow flags
  always_ff @(posedge clk) begin
    if (!rst_n) r_flags <= 3'b000;
    else        r_flags <= flag_next(r_flags, w_flag_set, bus.flag_clr);
  end

  assign bus.tcnt     = r_tcnt;
  assign bus.count_en = w_count_en;
  assign bus.cmfa     = r_flags[FLG_CMFA];
  assign bus.cmfb     = r_flags[FLG_CMFB];
  assign bus.ovf      = r_flags[FLG_OVF];
  assign bus.irq      = |(r_flags & bus.int_en);

endmodule

// File: tb/tb_tmr_count_ctrl.sv
// Scoreboard bench for tmr_count_ctrl: stimulus queues cycle-stamped
// expectations, a negedge monitor pops and compares them.
module tb_tmr_count_ctrl;

  logic clk = 1'b0;
  logic rst_n;
  logic tmci;

  tmr_count_ctrl_if #(.BIT_WIDTH(8)) bus ();

  tmr_count_ctrl #(.BIT_WIDTH(8), .PSC_WIDTH(13)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tmci  (tmci),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Edge counter: after posedge n (and until the next one) cyc == n
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef enum int {K_TCNT, K_CE, K_CMFA, K_CMFB, K_OVF, K_IRQ} kind_t;
  typedef struct {
    int          when;
    kind_t       kind;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_pass = 0;

  function automatic void expect_at(input int when, input kind_t kind,
                                    input int val, input string name);
    exp_t e;
    int   idx;
    e.when = when;
    e.kind = kind;
    e.val  = val;
    e.name = name;
    idx = sb.size();
    while (idx > 0 && sb[idx-1].when > when) idx--;
    sb.insert(idx, e);
  endfunction

  // Monitor: compare every expectation due at this cycle
  exp_t        m_e;
  logic [31:0] m_act;
  always @(negedge clk) begin
    while (sb.size() != 0 && sb[0].when <= cyc) begin
      m_e = sb.pop_front();
      case (m_e.kind)
        K_TCNT:  m_act = {24'd0, bus.tcnt};
        K_CE:    m_act = {31'd0, bus.count_en};
        K_CMFA:  m_act = {31'd0, bus.cmfa};
        K_CMFB:  m_act = {31'd0, bus.cmfb};
        K_OVF:   m_act = {31'd0, bus.ovf};
        default: m_act = {31'd0, bus.irq};
      endcase
      n_chk++;
      if (m_e.when != cyc)
        $display("FAIL %s: check for edge %0d reached late at edge %0d", m_e.name, m_e.when, cyc);
      else if (m_act === m_e.val)
        n_pass++;
      else
        $display("FAIL %s @edge %0d: got 0x%0h, expected 0x%0h", m_e.name, cyc, m_act, m_e.val);
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic cfg(input logic [2:0] cks, input logic [1:0] edg, input logic [1:0] cclr,
                     input logic [7:0] a, input logic [7:0] b, input logic [2:0] ie);
    bus.tcr_cks  = cks;
    bus.tcr_edge = edg;
    bus.tcr_cclr = cclr;
    bus.tcora    = a;
    bus.tcorb    = b;
    bus.int_en   = ie;
  endtask

  // Leaves rst_n released just after the last edge that sampled it low
  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
  endtask

  int R;
  int T;

  initial begin
    rst_n            = 1'b0;
    tmci             = 1'b0;
    bus.tcnt_wr_en   = 1'b0;
    bus.tcnt_wr_data = 8'h00;
    bus.flag_clr     = 3'b000;
    cfg(3'b000, 2'b00, 2'b00, 8'h00, 8'h00, 3'b000);

    // P/2 free run: match at 0x80, overflow, OVF set-vs-clear collision
    cfg(3'b001, 2'b00, 2'b00, 8'h80, 8'h80, 3'b001);
    do_reset();
    R = cyc;
    expect_at(R+1,   K_TCNT, 0,     "rst_tcnt");
    expect_at(R+1,   K_CMFA, 0,     "rst_cmfa");
    expect_at(R+1,   K_OVF,  0,     "rst_ovf");
    expect_at(R+1,   K_IRQ,  0,     "rst_irq");
    expect_at(R+1,   K_CE,   1,     "p2_first_tick");
    expect_at(R+2,   K_TCNT, 1,     "p2_tcnt_e2");
    expect_at(R+2,   K_CE,   0,     "p2_no_tick_e2");
    expect_at(R+4,   K_TCNT, 2,     "p2_tcnt_e4");
    expect_at(R+257, K_TCNT, 8'h80, "p2_tcnt_e257");
    expect_at(R+257, K_CMFA, 0,     "p2_cmfa_pre");
    expect_at(R+258, K_TCNT, 8'h81, "p2_tcnt_e258");
    expect_at(R+258, K_CMFA, 1,     "p2_cmfa_set");
    expect_at(R+258, K_CMFB, 1,     "p2_cmfb_set");
    expect_at(R+258, K_IRQ,  1,     "p2_irq_cmia");
    expect_at(R+511, K_TCNT, 8'hFF, "p2_tcnt_e511");
    expect_at(R+511, K_OVF,  0,     "p2_ovf_pre");
    step(511);
    bus.flag_clr = 3'b100;
    expect_at(R+512, K_TCNT, 0, "ovf_tcnt_wrap");
    expect_at(R+512, K_OVF,  1, "ovf_set_wins");
    expect_at(R+512, K_IRQ,  1, "ovf_irq");
    step(1);
    bus.flag_clr = 3'b000;
    bus.int_en   = 3'b100;
    step(1);
    bus.flag_clr = 3'b100;
    expect_at(R+513, K_OVF,  1, "ovf_hold");
    expect_at(R+513, K_IRQ,  1, "ovf_irq_only");
    expect_at(R+514, K_OVF,  0, "ovf_cleared");
    expect_at(R+514, K_IRQ,  0, "ovf_irq_off");
    expect_at(R+514, K_CMFA, 1, "cmfa_still_set");
    step(1);
    bus.flag_clr = 3'b000;
    step(2);

    // P/32 with clear on match A at 4
    cfg(3'b011, 2'b00, 2'b01, 8'h04, 8'h80, 3'b000);
    do_reset();
    R = cyc;
    expect_at(R+31,  K_CE,   1, "p32_first_tick");
    expect_at(R+31,  K_TCNT, 0, "p32_tcnt_e31");
    expect_at(R+32,  K_TCNT, 1, "p32_tcnt_e32");
    expect_at(R+159, K_TCNT, 4, "p32_tcnt_e159");
    expect_at(R+159, K_CMFA, 0, "p32_cmfa_pre");
    expect_at(R+160, K_TCNT, 0, "p32_clear_a");
    expect_at(R+160, K_CMFA, 1, "p32_cmfa_set");
    expect_at(R+192, K_TCNT, 1, "p32_tcnt_e192");
    expect_at(R+319, K_TCNT, 4, "p32_tcnt_e319");
    expect_at(R+320, K_TCNT, 0, "p32_period");
    expect_at(R+320, K_OVF,  0, "p32_no_ovf");
    expect_at(R+320, K_CMFB, 0, "p32_no_cmfb");
    step(322);

    // External clock, both edges then falling only
    cfg(3'b111, 2'b10, 2'b00, 8'hF0, 8'hF0, 3'b000);
    tmci = 1'b0;
    do_reset();
    step(2);
    for (int i = 1; i <= 10; i++) begin
      tmci = ~tmci;
      T = cyc;
      expect_at(T+2, K_TCNT, i-1, $sformatf("ext_both_pre%0d", i));
      expect_at(T+3, K_TCNT, i,   $sformatf("ext_both_inc%0d", i));
      step(4);
    end
    bus.tcr_edge = 2'b01;
    step(2);
    for (int i = 1; i <= 5; i++) begin
      tmci = 1'b1;
      T = cyc;
      expect_at(T+3, K_TCNT, 10+i-1, $sformatf("ext_fall_rise%0d", i));
      step(4);
      tmci = 1'b0;
      T = cyc;
      expect_at(T+2, K_TCNT, 10+i-1, $sformatf("ext_fall_pre%0d", i));
      expect_at(T+3, K_TCNT, 10+i,   $sformatf("ext_fall_inc%0d", i));
      step(4);
    end
    expect_at(cyc+1, K_TCNT, 15, "ext_final");
    step(2);

    // CPU write on a matching tick suppresses the match
    cfg(3'b001, 2'b00, 2'b00, 8'h80, 8'h03, 3'b000);
    do_reset();
    R = cyc;
    expect_at(R+7, K_TCNT, 3, "wr_tcnt_pre");
    expect_at(R+7, K_CE,   1, "wr_tick_pre");
    step(7);
    bus.tcnt_wr_en   = 1'b1;
    bus.tcnt_wr_data = 8'h7F;
    expect_at(R+8, K_TCNT, 8'h7F, "wr_load");
    expect_at(R+8, K_CMFB, 0,     "wr_cmfb_suppressed");
    step(1);
    bus.tcnt_wr_en = 1'b0;
    expect_at(R+10, K_TCNT, 8'h80, "wr_then_count");
    expect_at(R+10, K_CMFB, 0,     "wr_cmfb_stays");
    expect_at(R+10, K_CMFA, 0,     "wr_cmfa_stays");
    step(3);

    // Clear on match B
    cfg(3'b001, 2'b00, 2'b10, 8'h80, 8'h02, 3'b000);
    do_reset();
    R = cyc;
    expect_at(R+5, K_TCNT, 2, "clrb_tcnt_pre");
    expect_at(R+6, K_TCNT, 0, "clrb_clear");
    expect_at(R+6, K_CMFB, 1, "clrb_cmfb");
    expect_at(R+6, K_CMFA, 0, "clrb_cmfa");
    expect_at(R+8, K_TCNT, 1, "clrb_restart");
    step(9);

    // Clear on match A at all-ones: match flag only, no overflow
    cfg(3'b001, 2'b00, 2'b01, 8'hFF, 8'h80, 3'b000);
    do_reset();
    R = cyc;
    expect_at(R+511, K_TCNT, 8'hFF, "ff_tcnt_pre");
    expect_at(R+512, K_TCNT, 0,     "ff_clear");
    expect_at(R+512, K_CMFA, 1,     "ff_cmfa");
    expect_at(R+512, K_OVF,  0,     "ff_no_ovf");
    step(513);

    // P/8, reach 0x33 with CMFA set, then a one-edge reset
    cfg(3'b010, 2'b00, 2'b00, 8'h32, 8'h80, 3'b001);
    do_reset();
    R = cyc;
    bus.tcnt_wr_en   = 1'b1;
    bus.tcnt_wr_data = 8'h32;
    expect_at(R+8,  K_TCNT, 8'h33, "p8_tcnt_33");
    expect_at(R+8,  K_CMFA, 1,     "p8_cmfa");
    expect_at(R+8,  K_IRQ,  1,     "p8_irq");
    expect_at(R+9,  K_TCNT, 0,     "rst2_tcnt");
    expect_at(R+9,  K_CMFA, 0,     "rst2_cmfa");
    expect_at(R+9,  K_CMFB, 0,     "rst2_cmfb");
    expect_at(R+9,  K_OVF,  0,     "rst2_ovf");
    expect_at(R+9,  K_IRQ,  0,     "rst2_irq");
    expect_at(R+9,  K_CE,   0,     "rst2_ce");
    expect_at(R+16, K_TCNT, 0,     "rst2_tcnt_e7");
    expect_at(R+17, K_TCNT, 1,     "rst2_tcnt_e8");
    step(1);
    bus.tcnt_wr_en = 1'b0;
    step(7);
    rst_n = 1'b0;
    step(1);
    rst_n = 1'b1;
    step(10);

    step(3);
    while (sb.size() != 0) begin
      m_e = sb.pop_front();
      n_chk++;
      $display("FAIL %s: never checked (due edge %0d, now %0d)", m_e.name, m_e.when, cyc);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: run exceeded time limit at edge %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule

// File: doc/tmr_count_ctrl.md
Name: tmr_count_ctrl

Overview:
Count-control sequencer for one 8-bit timer channel. Owns the free-running prescaler and the external-clock edge detector, and selects the count source per CKS. Drives the TCNT counter, including compare-match A/B, clear-on-match, overflow and the sticky flags. It sits between the register interface (TCR/TCORA/TCORB/TCSR) and the interrupt controller, and exports its count-enable pulse for channel cascading.

Parameters:
BIT_WIDTH, 8, counter/compare width
PSC_WIDTH, 13, prescaler width (covers P/8192)

Ports:
clk  in  1  system clock P
rst_n  in  1  synchronous active-low reset
tcr_cks  in  3  source select: 000 stop, 001 P/2, 010 P/8, 011 P/32, 100 P/64, 101 P/1024, 110 P/8192, 111 external
tcr_edge  in  2  external edge: 00 rising, 01 falling, 10 both, 11 rising
tcr_cclr  in  2  clear mode: 00 none, 01 on match A, 10 on match B, 11 none
tmci  in  1  external clock, asynchronous
tcora  in  BIT_WIDTH  compare value A
tcorb  in  BIT_WIDTH  compare value B
tcnt_wr_en  in  1  CPU write strobe to TCNT
tcnt_wr_data  in  BIT_WIDTH  CPU write data
flag_clr  in  3  one-cycle clear pulses [0]=CMFA [1]=CMFB [2]=OVF
int_en  in  3  enables [0]=CMIEA [1]=CMIEB [2]=OVIE
tcnt  out  BIT_WIDTH  counter value
count_en  out  1  one-cycle tick, selected source
cmfa, cmfb, ovf  out  1 each  sticky flags
irq  out  1  OR of (flag AND enable)

Behaviour:
- Reset: while rst_n=0 at a clk edge, the following are all 0: prescaler, synchronizer/edge flops, tcnt and all three flags. Consequently count_en=0 and irq=0.
- Prescaler: psc increments every clk and wraps at 2^PSC_WIDTH. The P/N tick is asserted when psc[log2N-1:0] is all ones. The first P/N tick falls N-1 cycles after reset release, so tcnt=1 after N edges.
- External path: 2-flop synchronizer followed by an edge flop.
  - Rising = s2&~s3; falling = ~s2&s3; both = s2^s3.
  - A tmci edge produces count_en on the 3rd clk edge after it.
  - Minimum high/low width is 2 clk; narrower pulses may be lost.
- count_en: combinational select of the tick, 0 when cks=000.
- CKS/edge change mid-operation: no prescaler reset and no spurious tick; the new source is effective the same cycle.
- Match events: mA = count_en & (tcnt==tcora); mB = count_en & (tcnt==tcorb). Both are evaluated on the pre-update tcnt.
- tcnt next-value priority:
  1. rst_n
  2. tcnt_wr_en loads tcnt_wr_data; all events that cycle are suppressed, so no flag is set
  3. clear: (cclr=01 & mA) or (cclr=10 & mB) gives 0
  4. count_en increments modulo 2^BIT_WIDTH
  5. otherwise hold
- Clear-on-match: with tcora=K and cclr=01, the sequence is 0..K,0 and the period is K+1 ticks.
- OVF: set only when an increment wraps all-ones to 0. A clear caused by a match at tcnt=all-ones sets the match flag only, not OVF.
- Flags: set on their event and cleared by the flag_clr pulse. If set and clear occur in the same cycle, set wins. Flags are independent; mA and mB may both set in one cycle.
- irq: combinational from the flag registers and int_en, with no added latency beyond the flag register.
- cks=000: tcnt holds, the prescaler keeps running, and CPU writes still apply.

Decomposition:
- Package tmr_pkg holds:
  - CKS_* encodings, EDGE_* encodings, CCLR_* encodings
  - flag index constants FLG_CMFA/FLG_CMFB/FLG_OVF
  - the tap table mapping CKS to log2N
- Sub-module tmr_prescaler contains psc and per-tap tick generation, with outputs tick[5:0].
- The synchronizer, edge detect, counter and flags stay in tmr_count_ctrl.

Test Plan:
- Reset release with cks=001, cclr=00, tcora=tcorb=0x80: tcnt=1 at edge 2 and steps every 2 clk. At edge 512, tcnt=0 and ovf=1. At edge 258, cmfa=cmfb=1 (tick with tcnt=0x80); with int_en=3'b001, irq=1 from then.
- cks=011 (P/32), tcora=0x04, cclr=01: tcnt cycles 0,1,2,3,4,0. cmfa is set at edge 160 (5th tick), the period is 160 clk, and ovf never sets.
- cks=111, edge=10, tmci toggled 10 times at 4 clk high/low: tcnt=10, each increment 3 edges after a tmci edge. Switching to edge=01 with 5 further pulses gives tcnt=15.
- tcnt_wr_en with data 0x7F on a tick where tcnt==tcorb: tcnt=0x7F next cycle, cmfb stays 0.
- flag_clr[2] asserted in the same cycle as an overflow: ovf=1 afterwards. With int_en[2]=1, irq=1. flag_clr[2] alone next cycle gives ovf=0 and irq=0.
- cks=010, tcnt=0x33 with cmfa=1, then rst_n low for 1 edge: all outputs 0. The next tcnt increment comes 8 edges after release.
